// File: rtl/ftdi_pkt_reader.sv
// rtl/ftdi_pkt_reader.sv - FT232H 245-FIFO packet reader with a one-packet buffer and a valid/ready byte drain
module ftdi_pkt_reader #(
   parameter logic [7:0] START_SEQ      = 8'hA5,
   parameter logic [7:0] STOP_SEQ       = 8'hC3,
   parameter int         START_PKT_LEN  = 8,
   parameter int         STOP_PKT_LEN   = 2,
   parameter int         RD_LOW_CYCLES  = 4,
   parameter int         RD_HIGH_CYCLES = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ftdi_rxf,
   output logic       ftdi_rd,
   input  logic [7:0] ftdi_data,
   output logic [7:0] pkt_data,
   output logic       pkt_valid,
   input  logic       pkt_ready,
   output logic       pkt_first,
   output logic       pkt_last,
   output logic       pkt_is_stop,
   output logic       bad_header,
   output logic       busy
);

   localparam int MAX_LEN = (START_PKT_LEN > STOP_PKT_LEN) ? START_PKT_LEN : STOP_PKT_LEN;
   localparam int IDX_W   = $clog2(MAX_LEN + 1);
   localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int CNT_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0] START_LEN = IDX_W'(START_PKT_LEN);
   localparam logic [IDX_W-1:0] STOP_LEN  = IDX_W'(STOP_PKT_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RD_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(RD_HIGH_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD_LOW,
      S_RD_HIGH,
      S_DRAIN
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             rxf_m;
   logic             rxf_s;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       byte_r;
   logic [7:0]       pkt_buf [MAX_LEN];
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] rd_next;
   logic [IDX_W-1:0] pkt_len;
   logic             stop_r;

   logic latch_byte;
   logic take_byte;
   logic handshake;
   logic last_hs;
   logic hdr_start;
   logic hdr_stop;
   logic store_byte;

   assign hdr_start  = (byte_r == START_SEQ);
   assign hdr_stop   = (byte_r == STOP_SEQ);
   assign rd_next    = rd_idx + IDX_ONE;
   assign store_byte = take_byte && ((wr_idx != '0) || hdr_start || hdr_stop);
   assign busy       = !((state == S_IDLE) && (wr_idx == '0));

   always_comb begin
      state_next = state;
      latch_byte = 1'b0;
      take_byte  = 1'b0;
      handshake  = pkt_valid && pkt_ready;
      last_hs    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rxf_s) state_next = S_RD_LOW;
         end
         S_RD_LOW: begin
            if (cnt == LOW_LAST) begin
               latch_byte = 1'b1;
               state_next = S_RD_HIGH;
            end
         end
         S_RD_HIGH: begin
            take_byte = (cnt == '0);
            // wr_idx was updated in the first RD_HIGH cycle, so it is current here
            if (cnt == HIGH_LAST) state_next = (wr_idx == pkt_len) ? S_DRAIN : S_IDLE;
         end
         S_DRAIN: begin
            if (handshake && (rd_idx == pkt_len - IDX_ONE)) begin
               last_hs    = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (store_byte) pkt_buf[wr_idx[AW-1:0]] <= byte_r;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         rxf_m       <= 1'b1;
         rxf_s       <= 1'b1;
         cnt         <= '0;
         ftdi_rd     <= 1'b1;
         byte_r      <= 8'h00;
         wr_idx      <= '0;
         rd_idx      <= '0;
         pkt_len     <= START_LEN;
         stop_r      <= 1'b0;
         bad_header  <= 1'b0;
         pkt_valid   <= 1'b0;
         pkt_data    <= 8'h00;
         pkt_first   <= 1'b0;
         pkt_last    <= 1'b0;
         pkt_is_stop <= 1'b0;
      end else begin
         state   <= state_next;
         rxf_m   <= ftdi_rxf;
         rxf_s   <= rxf_m;
         ftdi_rd <= (state_next != S_RD_LOW);

         if (((state == S_RD_LOW) || (state == S_RD_HIGH)) && (state_next == state))
            cnt <= cnt + CNT_ONE;
         else
            cnt <= '0;

         if (latch_byte) byte_r <= ftdi_data;

         bad_header <= take_byte && (wr_idx == '0) && !hdr_start && !hdr_stop;

         if (take_byte) begin
            if (wr_idx == '0) begin
               if (hdr_start || hdr_stop) begin
                  wr_idx  <= IDX_ONE;
                  pkt_len <= hdr_stop ? STOP_LEN : START_LEN;
                  stop_r  <= hdr_stop;
               end
            end else begin
               wr_idx <= wr_idx + IDX_ONE;
            end
         end

         // Output registers are loaded one step ahead so pkt_valid never sees pkt_ready combinationally
         if ((state != S_DRAIN) && (state_next == S_DRAIN)) begin
            pkt_valid   <= 1'b1;
            pkt_data    <= pkt_buf[0];
            pkt_first   <= 1'b1;
            pkt_last    <= (pkt_len == IDX_ONE);
            pkt_is_stop <= stop_r;
            rd_idx      <= '0;
         end else if ((state == S_DRAIN) && handshake) begin
            if (last_hs) begin
               pkt_valid <= 1'b0;
               pkt_first <= 1'b0;
               pkt_last  <= 1'b0;
               rd_idx    <= '0;
               wr_idx    <= '0;
            end else begin
               rd_idx    <= rd_next;
               pkt_data  <= pkt_buf[rd_next[AW-1:0]];
               pkt_first <= 1'b0;
               pkt_last  <= (rd_next == pkt_len - IDX_ONE);
            end
         end
      end
   end

endmodule

// File: tb/tb_ftdi_pkt_reader.sv
// tb/tb_ftdi_pkt_reader.sv - directed bench for ftdi_pkt_reader with an FTDI FIFO model and output monitor
module tb_ftdi_pkt_reader;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ftdi_rxf;
   logic       ftdi_rd;
   logic [7:0] ftdi_data;
   logic [7:0] pkt_data;
   logic       pkt_valid;
   logic       pkt_ready = 1'b0;
   logic       pkt_first;
   logic       pkt_last;
   logic       pkt_is_stop;
   logic       bad_header;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] ftdi_q[$];
   int gap_at   = -1;
   int gap_left = 0;
   logic prev_rd = 1'b1;
   int rd_pulses, low_run, high_run = 100, low_err, high_err;
   int bad_cnt, rd_while_valid, gap_rd_low;
   logic [7:0] out_data[$];
   logic       out_first[$];
   logic       out_last[$];
   logic       out_stop[$];

   ftdi_pkt_reader dut (
      .clock      (clock),
      .reset      (reset),
      .ftdi_rxf   (ftdi_rxf),
      .ftdi_rd    (ftdi_rd),
      .ftdi_data  (ftdi_data),
      .pkt_data   (pkt_data),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .pkt_first  (pkt_first),
      .pkt_last   (pkt_last),
      .pkt_is_stop(pkt_is_stop),
      .bad_header (bad_header),
      .busy       (busy)
   );

   always #10 clock = ~clock;

   initial begin
      ftdi_rxf  = 1'b1;
      ftdi_data = 8'hFF;
   end

   // FTDI FIFO model plus monitors, all on the falling edge
   always @(negedge clock) begin
      if (gap_left > 0) gap_left--;
      if (!reset) begin
         if (pkt_valid && pkt_ready) begin
            out_data.push_back(pkt_data);
            out_first.push_back(pkt_first);
            out_last.push_back(pkt_last);
            out_stop.push_back(pkt_is_stop);
         end
         if (bad_header === 1'b1) bad_cnt++;
         if (pkt_valid === 1'b1 && ftdi_rd === 1'b0) rd_while_valid++;
      end
      if (gap_left > 0 && ftdi_rd === 1'b0) gap_rd_low++;
      if (prev_rd == 1'b0 && ftdi_rd === 1'b1) begin
         rd_pulses++;
         if (low_run != 4) low_err++;
         low_run  = 0;
         high_run = 1;
         if (ftdi_q.size() > 0) void'(ftdi_q.pop_front());
         if (rd_pulses == gap_at) gap_left = 20;
      end else if (prev_rd == 1'b1 && ftdi_rd === 1'b0) begin
         if (rd_pulses > 0 && high_run < 3) high_err++;
         high_run = 0;
         low_run  = 1;
      end else if (ftdi_rd === 1'b0) begin
         low_run++;
      end else begin
         high_run++;
      end
      prev_rd   = (ftdi_rd === 1'b0) ? 1'b0 : 1'b1;
      ftdi_rxf  = (ftdi_q.size() == 0) || (gap_left > 0);
      ftdi_data = (ftdi_q.size() > 0) ? ftdi_q[0] : 8'hFF;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_mon();
      rd_pulses = 0; low_err = 0; high_err = 0; bad_cnt = 0;
      rd_while_valid = 0; gap_rd_low = 0; gap_at = -1;
      out_data.delete(); out_first.delete(); out_last.delete(); out_stop.delete();
   endtask

   task automatic wait_out(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         tick();
         if (out_data.size() >= n) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      int rd_low_seen;
      reset = 1'b1;
      repeat (3) tick();
      checks++; if (ftdi_rd !== 1'b1) begin failures++; $display("FAIL reset_ftdi_rd: got %b expected 1", ftdi_rd); end
      checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL reset_pkt_valid: got %b expected 0", pkt_valid); end
      checks++; if ({pkt_first, pkt_last, pkt_is_stop} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {pkt_first, pkt_last, pkt_is_stop}); end
      checks++; if (bad_header !== 1'b0) begin failures++; $display("FAIL reset_bad_header: got %b expected 0", bad_header); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      reset = 1'b0;
      rd_low_seen = 0;
      repeat (10) begin
         tick();
         if (ftdi_rd !== 1'b1) rd_low_seen++;
      end
      checks++; if (rd_low_seen != 0) begin failures++; $display("FAIL idle_no_read: got %0d low cycles expected 0", rd_low_seen); end
   endtask

   task automatic test_start_packet();
      logic [7:0] exp_d[$];
      bit ok;
      clear_mon();
      exp_d = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      pkt_ready = 1'b1;
      foreach (exp_d[i]) ftdi_q.push_back(exp_d[i]);
      wait_out(8, 300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL start_timeout: got %0d bytes expected 8", out_data.size()); end
      foreach (exp_d[i]) begin
         checks++;
         if (out_data[i] !== exp_d[i] || out_first[i] !== (i == 0) || out_last[i] !== (i == 7) || out_stop[i] !== 1'b0) begin
            failures++;
            $display("FAIL start_byte%0d: got data=%h first=%b last=%b stop=%b expected data=%h first=%b last=%b stop=0",
                     i, out_data[i], out_first[i], out_last[i], out_stop[i], exp_d[i], (i == 0), (i == 7));
         end
      end
      checks++; if (rd_pulses != 8) begin failures++; $display("FAIL start_rd_pulses: got %0d expected 8", rd_pulses); end
      checks++; if (low_err != 0 || high_err != 0) begin failures++; $display("FAIL start_rd_widths: got low_err=%0d high_err=%0d expected 0/0", low_err, high_err); end
      repeat (2) tick();
      checks++; if (busy !== 1'b0 || pkt_valid !== 1'b0) begin failures++; $display("FAIL start_idle_after: got busy=%b valid=%b expected 0/0", busy, pkt_valid); end
   endtask

   task automatic test_stop_packet();
      logic [7:0] exp_d[$];
      bit ok;
      clear_mon();
      exp_d = '{8'hC3, 8'h01};
      pkt_ready = 1'b1;
      foreach (exp_d[i]) ftdi_q.push_back(exp_d[i]);
      wait_out(2, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL stop_timeout: got %0d bytes expected 2", out_data.size()); end
      checks++; if (busy !== 1'b0 || pkt_valid !== 1'b0) begin failures++; $display("FAIL stop_busy_drop: got busy=%b valid=%b expected 0/0", busy, pkt_valid); end
      foreach (exp_d[i]) begin
         checks++;
         if (out_data[i] !== exp_d[i] || out_first[i] !== (i == 0) || out_last[i] !== (i == 1) || out_stop[i] !== 1'b1) begin
            failures++;
            $display("FAIL stop_byte%0d: got data=%h first=%b last=%b stop=%b expected data=%h first=%b last=%b stop=1",
                     i, out_data[i], out_first[i], out_last[i], out_stop[i], exp_d[i], (i == 0), (i == 1));
         end
      end
      checks++; if (rd_pulses != 2) begin failures++; $display("FAIL stop_rd_pulses: got %0d expected 2", rd_pulses); end
   endtask

   task automatic test_bad_header();
      logic [7:0] exp_d[$];
      bit ok;
      clear_mon();
      exp_d = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      pkt_ready = 1'b1;
      ftdi_q.push_back(8'h00);
      foreach (exp_d[i]) ftdi_q.push_back(exp_d[i]);
      wait_out(8, 300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL bad_timeout: got %0d bytes expected 8", out_data.size()); end
      checks++; if (bad_cnt != 1) begin failures++; $display("FAIL bad_header_pulses: got %0d expected 1", bad_cnt); end
      foreach (exp_d[i]) begin
         checks++;
         if (out_data[i] !== exp_d[i] || out_first[i] !== (i == 0) || out_last[i] !== (i == 7)) begin
            failures++;
            $display("FAIL bad_byte%0d: got data=%h first=%b last=%b expected data=%h first=%b last=%b",
                     i, out_data[i], out_first[i], out_last[i], exp_d[i], (i == 0), (i == 7));
         end
      end
      checks++; if (rd_pulses != 9) begin failures++; $display("FAIL bad_rd_pulses: got %0d expected 9", rd_pulses); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_d[$];
      bit ok;
      bit found;
      int hold_err;
      clear_mon();
      exp_d = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hC3, 8'h09};
      pkt_ready = 1'b1;
      foreach (exp_d[i]) ftdi_q.push_back(exp_d[i]);
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         tick();
         if (pkt_valid === 1'b1 && pkt_data === 8'h03) found = 1'b1;
      end
      pkt_ready = 1'b0;
      checks++; if (!found) begin failures++; $display("FAIL bp_reach_idx3: got no 03 byte expected 03 presented"); end
      hold_err = 0;
      repeat (10) begin
         tick();
         if (pkt_valid !== 1'b1 || pkt_data !== 8'h03 || pkt_first !== 1'b0 || pkt_last !== 1'b0 || ftdi_rd !== 1'b1) hold_err++;
      end
      checks++; if (hold_err != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_err); end
      checks++; if (ftdi_q.size() != 2) begin failures++; $display("FAIL bp_no_read: got %0d bytes left in FIFO expected 2", ftdi_q.size()); end
      pkt_ready = 1'b1;
      wait_out(10, 300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL bp_timeout: got %0d bytes expected 10", out_data.size()); end
      foreach (exp_d[i]) begin
         checks++;
         if (out_data[i] !== exp_d[i] || out_first[i] !== (i == 0 || i == 8) || out_last[i] !== (i == 7 || i == 9) || out_stop[i] !== (i >= 8)) begin
            failures++;
            $display("FAIL bp_byte%0d: got data=%h first=%b last=%b stop=%b expected data=%h first=%b last=%b stop=%b",
                     i, out_data[i], out_first[i], out_last[i], out_stop[i], exp_d[i], (i == 0 || i == 8), (i == 7 || i == 9), (i >= 8));
         end
      end
      checks++; if (rd_while_valid != 0) begin failures++; $display("FAIL bp_rd_during_drain: got %0d expected 0", rd_while_valid); end
      checks++; if (out_data.size() != 10) begin failures++; $display("FAIL bp_count: got %0d expected 10", out_data.size()); end
   endtask

   task automatic test_rxf_gap();
      logic [7:0] exp_d[$];
      bit ok;
      clear_mon();
      gap_at = 3;
      exp_d = '{8'hA5, 8'h11, 8'h22, 8'hA5, 8'hC3, 8'h55, 8'h66, 8'h77};
      pkt_ready = 1'b1;
      foreach (exp_d[i]) ftdi_q.push_back(exp_d[i]);
      wait_out(8, 400, ok);
      checks++; if (!ok) begin failures++; $display("FAIL gap_timeout: got %0d bytes expected 8", out_data.size()); end
      checks++; if (gap_rd_low != 0) begin failures++; $display("FAIL gap_rd_low: got %0d low cycles expected 0", gap_rd_low); end
      foreach (exp_d[i]) begin
         checks++;
         if (out_data[i] !== exp_d[i] || out_first[i] !== (i == 0) || out_last[i] !== (i == 7) || out_stop[i] !== 1'b0) begin
            failures++;
            $display("FAIL gap_byte%0d: got data=%h first=%b last=%b stop=%b expected data=%h first=%b last=%b stop=0",
                     i, out_data[i], out_first[i], out_last[i], out_stop[i], exp_d[i], (i == 0), (i == 7));
         end
      end
      checks++; if (rd_pulses != 8) begin failures++; $display("FAIL gap_rd_pulses: got %0d expected 8", rd_pulses); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp_d[$];
      bit ok;
      bit found;
      clear_mon();
      exp_d = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      pkt_ready = 1'b1;
      foreach (exp_d[i]) ftdi_q.push_back(exp_d[i]);
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         tick();
         if (rd_pulses == 4 && ftdi_rd === 1'b0) found = 1'b1;
      end
      checks++; if (!found) begin failures++; $display("FAIL rst_reach_byte5: got %0d pulses expected to reach byte 5 read", rd_pulses); end
      reset = 1'b1;
      ftdi_q.delete();
      tick();
      checks++; if (ftdi_rd !== 1'b1 || pkt_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_outputs: got rd=%b valid=%b expected 1/0", ftdi_rd, pkt_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
      tick();
      reset = 1'b0;
      clear_mon();
      foreach (exp_d[i]) ftdi_q.push_back(exp_d[i]);
      wait_out(8, 300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rst_timeout: got %0d bytes expected 8", out_data.size()); end
      foreach (exp_d[i]) begin
         checks++;
         if (out_data[i] !== exp_d[i] || out_first[i] !== (i == 0) || out_last[i] !== (i == 7)) begin
            failures++;
            $display("FAIL rst_byte%0d: got data=%h first=%b last=%b expected data=%h first=%b last=%b",
                     i, out_data[i], out_first[i], out_last[i], exp_d[i], (i == 0), (i == 7));
         end
      end
      checks++; if (bad_cnt != 0 || rd_pulses != 8) begin failures++; $display("FAIL rst_clean_restart: got bad=%0d pulses=%0d expected 0/8", bad_cnt, rd_pulses); end
   endtask

   initial begin
      test_reset();
      test_start_packet();
      test_stop_packet();
      test_bad_header();
      test_back_to_back();
      test_rxf_gap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
